// File: rtl/logc_pkg.sv
// ----------------------------------------------------------------------------
// logc_pkg : widths, code-splitting helper and saturation value for log chain
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package logc_pkg;

  localparam int DATA_WIDTH  = 48;
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);
  localparam int FRAC_WIDTH  = DATA_WIDTH / 2;
  localparam int LOG_WIDTH   = SHIFT_WIDTH + FRAC_WIDTH + 1;

  localparam logic [DATA_WIDTH-1:0] SAT_VALUE = {DATA_WIDTH{1'b1}};

  typedef struct packed {
    logic [SHIFT_WIDTH:0]  e;
    logic [FRAC_WIDTH-1:0] f;
  } log_code_t;

  function automatic log_code_t split_log(input logic [LOG_WIDTH-1:0] code);
    log_code_t lc;
    lc.e = code[LOG_WIDTH-1:FRAC_WIDTH];
    lc.f = code[FRAC_WIDTH-1:0];
    return lc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/antilog_shift.sv
// ----------------------------------------------------------------------------
// antilog_shift : builds the 1.f mantissa and barrel-shifts it by e-FRAC_WIDTH
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module antilog_shift #(
  parameter int DATA_WIDTH  = 48,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int FRAC_WIDTH  = DATA_WIDTH / 2
) (
  input  logic [SHIFT_WIDTH:0]  e_in,
  input  logic [FRAC_WIDTH-1:0] f_in,
  output logic [DATA_WIDTH-1:0] lin_out
);

  localparam int IW = DATA_WIDTH + FRAC_WIDTH + 1;
  localparam logic [SHIFT_WIDTH:0] FRAC_E = (SHIFT_WIDTH + 1)'(FRAC_WIDTH);

  logic [IW-1:0] mant_w;

  // Right shifts drop the fractional bits below the binary point (floor).
  always_comb begin
    mant_w = IW'({1'b1, f_in});
    if (e_in >= FRAC_E) begin
      lin_out = DATA_WIDTH'(mant_w << (e_in - FRAC_E));
    end else begin
      lin_out = DATA_WIDTH'(mant_w >> (FRAC_E - e_in));
    end
  end

endmodule

`default_nettype wire

// File: rtl/antilog_calc.sv
// ----------------------------------------------------------------------------
// antilog_calc : 3-stage valid/ready pipeline converting a log2 code to linear
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module antilog_calc #(
  parameter int DATA_WIDTH  = logc_pkg::DATA_WIDTH,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int FRAC_WIDTH  = DATA_WIDTH / 2,
  parameter int LOG_WIDTH   = SHIFT_WIDTH + FRAC_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOG_WIDTH-1:0]  log_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sat_out
);

  localparam logic [SHIFT_WIDTH:0]  DATA_E  = (SHIFT_WIDTH + 1)'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SAT_OUT = {DATA_WIDTH{1'b1}};

  logic                  s1_valid_q, s1_valid_d;
  logic [SHIFT_WIDTH:0]  s1_e_q, s1_e_d;
  logic [FRAC_WIDTH-1:0] s1_f_q, s1_f_d;
  logic                  s1_sat_q, s1_sat_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_lin_q, s2_lin_d;
  logic                  s2_sat_q, s2_sat_d;
  logic                  s3_valid_q, s3_valid_d;
  logic [DATA_WIDTH-1:0] s3_data_q, s3_data_d;
  logic                  s3_sat_q, s3_sat_d;

  logic                  rdy1, rdy2, rdy3;
  logic [SHIFT_WIDTH:0]  dec_e;
  logic [DATA_WIDTH-1:0] shift_lin;

  assign dec_e = log_in[LOG_WIDTH-1:FRAC_WIDTH];

  // Ready ripples back from the output so a full pipe still moves each cycle.
  assign rdy3 = !s3_valid_q || out_ready;
  assign rdy2 = !s2_valid_q || rdy3;
  assign rdy1 = !s1_valid_q || rdy2;

  assign in_ready  = rdy1;
  assign out_valid = s3_valid_q;
  assign data_out  = s3_data_q;
  assign sat_out   = s3_sat_q;

  antilog_shift #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .FRAC_WIDTH  (FRAC_WIDTH)
  ) u_shift (
    .e_in    (s1_e_q),
    .f_in    (s1_f_q),
    .lin_out (shift_lin)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_e_d     = s1_e_q;
    s1_f_d     = s1_f_q;
    s1_sat_d   = s1_sat_q;
    s2_valid_d = s2_valid_q;
    s2_lin_d   = s2_lin_q;
    s2_sat_d   = s2_sat_q;
    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
    s3_sat_d   = s3_sat_q;

    if (rdy1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_e_d   = dec_e;
        s1_f_d   = log_in[FRAC_WIDTH-1:0];
        s1_sat_d = (dec_e >= DATA_E);
      end
    end

    if (rdy2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_lin_d = shift_lin;
        s2_sat_d = s1_sat_q;
      end
    end

    if (rdy3) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_data_d = s2_sat_q ? SAT_OUT : s2_lin_q;
        s3_sat_d  = s2_sat_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_e_q     <= '0;
      s1_f_q     <= '0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_lin_q   <= '0;
      s2_sat_q   <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_e_q     <= s1_e_d;
      s1_f_q     <= s1_f_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      s2_lin_q   <= s2_lin_d;
      s2_sat_q   <= s2_sat_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
      s3_sat_q   <= s3_sat_d;
    end
  end

endmodule

`default_nettype wire
